// File: rtl/core_pkg.sv
// Shared encodings for the memory arbiter: FSM states and requester ids.
package core_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_MEM_REQ = 2'd1,
      ARB_MEM_REL = 2'd2,
      ARB_CLI_ACK = 2'd3
   } arb_state_t;

   localparam logic GNT_INST = 1'b0;
   localparam logic GNT_DATA = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker. Purely combinational; the caller owns last_grant.
module rr_arb2
   import core_pkg::*;
(
   input  logic req_i,
   input  logic req_d,
   input  logic last_grant,
   output logic gnt_valid,
   output logic gnt_id
);

   // Single requester wins outright; on a tie the port that did not win last time goes.
   always_comb begin
      gnt_valid = req_i | req_d;
      gnt_id    = GNT_INST;
      if (req_i && req_d) begin
         gnt_id = ~last_grant;
      end else if (req_d) begin
         gnt_id = GNT_DATA;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the fetch unit and the load/store path.
// All three sides use a four-phase req/valid handshake; a watchdog aborts memory
// accesses that never answer and reports them through the requester's err flag.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ARB_IDLE     | waiting for a request and for mem_valid to be low
//   ARB_MEM_REQ  | mem_req high, address/we/wdata held, watchdog running
//   ARB_MEM_REL  | mem_req dropped, waiting for the memory to drop mem_valid
//   ARB_CLI_ACK  | grantee's valid high until it drops its req
module mem_arbiter
   import core_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inst_req,
   input  logic [DATA_WIDTH-1:0] inst_addr,
   output logic                  inst_valid,
   output logic [DATA_WIDTH-1:0] inst_data,
   output logic                  inst_err,
   input  logic                  data_req,
   input  logic                  data_we,
   input  logic [DATA_WIDTH-1:0] data_addr,
   input  logic [DATA_WIDTH-1:0] data_wdata,
   output logic                  data_valid,
   output logic [DATA_WIDTH-1:0] data_rdata,
   output logic                  data_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_valid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam bit                   WDOG_EN  = (TIMEOUT != 0);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

   arb_state_t            state;
   logic [CNT_WIDTH-1:0]  wdog_cnt;
   logic                  gnt_id_q;
   logic                  last_grant;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;
   logic                  pick_valid;
   logic                  pick_id;
   logic                  gnt_req;

   rr_arb2 u_rr_arb2 (
      .req_i      (inst_req),
      .req_d      (data_req),
      .last_grant (last_grant),
      .gnt_valid  (pick_valid),
      .gnt_id     (pick_id)
   );

   assign gnt_req = (gnt_id_q == GNT_DATA) ? data_req : inst_req;

   // Arbitration FSM with registered memory-side and requester-side outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ARB_IDLE;
         wdog_cnt   <= '0;
         gnt_id_q   <= GNT_INST;
         last_grant <= GNT_DATA;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         inst_valid <= 1'b0;
         inst_data  <= '0;
         inst_err   <= 1'b0;
         data_valid <= 1'b0;
         data_rdata <= '0;
         data_err   <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               // A response still high here belongs to a transaction killed by reset.
               if (pick_valid && !mem_valid) begin
                  gnt_id_q   <= pick_id;
                  last_grant <= pick_id;
                  mem_req    <= 1'b1;
                  if (pick_id == GNT_DATA) begin
                     mem_addr  <= data_addr;
                     mem_we    <= data_we;
                     mem_wdata <= data_wdata;
                  end else begin
                     mem_addr  <= inst_addr;
                     mem_we    <= 1'b0;
                     mem_wdata <= '0;
                  end
                  state <= ARB_MEM_REQ;
               end
            end

            ARB_MEM_REQ: begin
               wdog_cnt <= wdog_cnt + 1'b1;
               // mem_valid is checked first so a response on the last cycle is not an error.
               if (mem_valid) begin
                  rdata_q <= mem_we ? '0 : mem_rdata;
                  err_q   <= 1'b0;
                  mem_req <= 1'b0;
                  state   <= ARB_MEM_REL;
               end else if (WDOG_EN && (wdog_cnt == CNT_LAST)) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  mem_req <= 1'b0;
                  state   <= ARB_MEM_REL;
               end
            end

            ARB_MEM_REL: begin
               if (!mem_valid) begin
                  wdog_cnt <= '0;
                  if (gnt_id_q == GNT_DATA) begin
                     data_valid <= 1'b1;
                     data_rdata <= rdata_q;
                     data_err   <= err_q;
                  end else begin
                     inst_valid <= 1'b1;
                     inst_data  <= rdata_q;
                     inst_err   <= err_q;
                  end
                  state <= ARB_CLI_ACK;
               end
            end

            ARB_CLI_ACK: begin
               if (!gnt_req) begin
                  inst_valid <= 1'b0;
                  inst_data  <= '0;
                  inst_err   <= 1'b0;
                  data_valid <= 1'b0;
                  data_rdata <= '0;
                  data_err   <= 1'b0;
                  state      <= ARB_IDLE;
               end
            end

            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule
